// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared types and encodings for the RV32I multicycle control FSM:
//            state enumeration, opcode constants, datapath mux encodings,
//            trap cause codes and small decode helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    // Opcodes understood by the controller
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA encodings
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALUOp encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // trap_cause encodings
    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // States that sit on the shared memory and may stall on mem_ready
    function automatic logic is_mem_wait(input state_t s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

    // Successor of DECODE for a given opcode; unknown opcodes trap
    function automatic state_t decode_next(input logic [6:0] opcode);
        state_t nxt;
        case (opcode)
            OP_LW, OP_SW: nxt = MEMADR;
            OP_R:         nxt = EXECR;
            OP_I:         nxt = EXECI;
            OP_JAL:       nxt = JAL;
            OP_BEQ:       nxt = BEQ;
            default:      nxt = TRAP;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mc_wait_timer
// Purpose  : Saturating wait-cycle counter used to detect a memory that never
//            answers. Counts enabled cycles, clears on request, and flags
//            when the count equals LIMIT (LIMIT = 0 disables the flag).
// Ports    : clk, rst (sync, active-high), clr (restart count at zero),
//            en (count this cycle), expired (count == LIMIT)
// Revision : 1.0 - initial release
// ============================================================================
module mc_wait_timer
    import mc_ctrl_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // At least one bit so a disabled timer still elaborates cleanly
    localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != {CNT_W{1'b1}})) begin
            // Hold at all-ones rather than wrapping back to zero
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expired = (LIMIT != 0) && (r_cnt == CNT_W'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Purpose  : Multicycle control FSM for the RV32I datapath. Sequences fetch,
//            decode, execute, memory and writeback; stalls on mem_ready;
//            traps on illegal opcodes and on memory timeouts.
// Ports    : clk, reset (sync, active-high), op (opcode from IR),
//            mem_ready (memory handshake) ->
//            mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
//            ResultSrc, ALUSrcA, ALUSrcB, ALUOp (datapath control),
//            instr_done (retire pulse), trap_cause (sticky trap reason)
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic [1:0] trap_cause
);

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_op;
    logic [1:0] r_trap;
    logic       w_tmr_clr;
    logic       w_tmr_en;
    logic       w_tmr_expired;

    // ------------------------------------------------------------------
    // Memory wait timer: restarts whenever a memory state is freshly
    // entered, counts the cycles memory leaves us hanging.
    // ------------------------------------------------------------------
    assign w_tmr_clr = is_mem_wait(w_next) && (w_next != r_state);
    assign w_tmr_en  = is_mem_wait(r_state) && !mem_ready;

    mc_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (reset),
        .clr     (w_tmr_clr),
        .en      (w_tmr_en),
        .expired (w_tmr_expired)
    );

    // ------------------------------------------------------------------
    // Next state. In memory states mem_ready is checked before the
    // timeout so a response on the limit cycle still completes.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH: begin
                if (mem_ready)          w_next = DECODE;
                else if (w_tmr_expired) w_next = TRAP;
            end
            DECODE:  w_next = decode_next(op);
            MEMADR:  w_next = (r_op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                if (mem_ready)          w_next = MEMWB;
                else if (w_tmr_expired) w_next = TRAP;
            end
            MEMWB:   w_next = FETCH;
            MEMWRITE: begin
                if (mem_ready)          w_next = FETCH;
                else if (w_tmr_expired) w_next = TRAP;
            end
            EXECR:   w_next = ALUWB;
            EXECI:   w_next = ALUWB;
            ALUWB:   w_next = FETCH;
            JAL:     w_next = ALUWB;
            BEQ:     w_next = FETCH;
            TRAP:    w_next = TRAP;
            default: w_next = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // State, latched opcode and trap cause. TRAP is absorbing, so the
    // cause is written exactly once, on the transition into it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_op    <= '0;
            r_trap  <= TRAP_NONE;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) begin
                r_op <= op;
            end
            if ((r_state != TRAP) && (w_next == TRAP)) begin
                r_trap <= (r_state == DECODE) ? TRAP_ILLEGAL : TRAP_TIMEOUT;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control outputs decoded from the state register. IRWrite/PCUpdate
    // in FETCH and instr_done in MEMWRITE follow mem_ready directly so the
    // commit lands on the handshake cycle. Reset forces everything low in
    // the same cycle, so a write in flight is dropped immediately.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCUpdate   = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ALUOp      = ALUOP_ADD;
        instr_done = 1'b0;
        case (r_state)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                mem_req    = 1'b1;
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                ALUOp   = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                PCUpdate = 1'b1;
            end
            BEQ: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                ALUOp      = ALUOP_SUB;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            mem_req    = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCUpdate   = 1'b0;
            Branch     = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ALUOp      = 2'b00;
            instr_done = 1'b0;
        end
    end

    assign trap_cause = reset ? TRAP_NONE : r_trap;

endmodule
`default_nettype wire
